// File: rtl/multicycle_addsub_pkg.sv
// multicycle_addsub_pkg: state encoding and size helpers shared by the chunk-serial add/sub unit.
package multicycle_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

   function automatic int cnt_width(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/multicycle_addsub_chunk_adder.sv
// multicycle_addsub_chunk_adder: combinational CHUNK-bit adder exposing the carry into the MSB.
module multicycle_addsub_chunk_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             cmsb
);

   assign {cmsb, s[CHUNK-2:0]} = {1'b0, a[CHUNK-2:0]} + {1'b0, b[CHUNK-2:0]} + CHUNK'(cin);
   assign {cout, s[CHUNK-1]}   = {1'b0, a[CHUNK-1]} + {1'b0, b[CHUNK-1]} + {1'b0, cmsb};

endmodule

// File: rtl/multicycle_addsub.sv
// multicycle_addsub: chunk-serial add/subtract with valid/ready handshakes,
// producing sum, carry-out, signed overflow and zero flags.
module multicycle_addsub #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   import multicycle_addsub_pkg::*;

   localparam int NCHUNK = nchunk(WIDTH, CHUNK);
   localparam int CW     = cnt_width(NCHUNK);

   state_t           state, state_nx;
   logic [WIDTH-1:0] opa, opb, sum_r;
   logic [CW-1:0]    cnt;
   logic             carry, cout_r, ovf_r, zero_r;
   logic [CHUNK-1:0] s_chunk;
   logic             c_chunk, c_msb, last, accept;

   multicycle_addsub_chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
      .a    (opa[CHUNK-1:0]),
      .b    (opb[CHUNK-1:0]),
      .cin  (carry),
      .s    (s_chunk),
      .cout (c_chunk),
      .cmsb (c_msb)
   );

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign last      = (cnt == CW'(NCHUNK - 1));
   assign sum       = sum_r;
   assign cout      = cout_r;
   assign ovf       = ovf_r;
   assign zero      = zero_r;

   always_comb begin
      state_nx = state;
      if (state == IDLE && in_valid) state_nx = RUN;
      else if (state == RUN && last) state_nx = DONE;
      else if (state == DONE && out_ready) state_nx = IDLE;
      else if (!(state inside {IDLE, RUN, DONE})) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end

   // Operands shift down so the adder always sees chunk k in the low CHUNK bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa    <= '0;
         opb    <= '0;
         sum_r  <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
         zero_r <= 1'b0;
      end else if (accept) begin
         opa   <= a;
         opb   <= sub ? ~b : b;
         carry <= sub | cin;
         cnt   <= '0;
      end else if (state == RUN) begin
         opa                       <= opa >> CHUNK;
         opb                       <= opb >> CHUNK;
         carry                     <= c_chunk;
         cnt                       <= cnt + CW'(1);
         sum_r[cnt*CHUNK +: CHUNK] <= s_chunk;
         if (last) begin
            cout_r <= c_chunk;
            ovf_r  <= c_chunk ^ c_msb;
            zero_r <= ~|{s_chunk, sum_r[WIDTH-CHUNK-1:0]};
         end
      end
   end

endmodule

// File: tb/tb_multicycle_addsub.sv
// tb_multicycle_addsub: directed table plus corner sequences and random ops,
// run on a 32/8 instance and a 16/4 instance driven in lockstep.
module tb_multicycle_addsub;

   typedef struct {
      logic [31:0] a, b;
      logic        cin, sub;
      logic [31:0] s;
      logic        c, o, z;
   } vec_t;

   typedef struct {
      logic [31:0] s;
      logic        c, o, z;
   } res_t;

   logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, cin = 0, sub = 0;
   logic [31:0] a = 0, b = 0;
   logic        in_ready, out_valid, cout, ovf, zero;
   logic [31:0] sum;
   logic        in_ready16, out_valid16, cout16, ovf16, zero16;
   logic [15:0] sum16;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   multicycle_addsub #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
   );

   multicycle_addsub #(.WIDTH(16), .CHUNK(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
      .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub), .out_valid(out_valid16), .out_ready(out_ready),
      .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic c, input logic s, input int w);
      logic [63:0] mask, xa, yb, full;
      res_t r;
      mask = (64'd1 << w) - 64'd1;
      xa   = {32'd0, x} & mask;
      yb   = (s ? ~{32'd0, y} : {32'd0, y}) & mask;
      full = xa + yb + {63'd0, s | c};
      r.s  = full[31:0] & mask[31:0];
      r.c  = full[w];
      r.o  = (xa[w-1] == yb[w-1]) && (full[w-1] != xa[w-1]);
      r.z  = (r.s == 0);
      return r;
   endfunction

   task automatic accept(input logic [31:0] ta, input logic [31:0] tb_, input logic tc, input logic ts);
      int n;
      @(negedge clk);
      a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1; out_ready = 0;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 0, 1);
      @(negedge clk);
      in_valid = 0;
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 1;
      while (!out_valid && n <= 20) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_latency"}, n - 1, 4);
      chk({nm, "_ov16"}, {31'd0, out_valid16}, 1);
   endtask

   task automatic check_res(input string nm, input res_t e32, input res_t e16);
      chk({nm, "_sum"}, sum, e32.s);
      chk({nm, "_cout"}, {31'd0, cout}, {31'd0, e32.c});
      chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, e32.o});
      chk({nm, "_zero"}, {31'd0, zero}, {31'd0, e32.z});
      chk({nm, "_sum16"}, {16'd0, sum16}, e16.s);
      chk({nm, "_flags16"}, {29'd0, cout16, ovf16, zero16}, {29'd0, e16.c, e16.o, e16.z});
   endtask

   task automatic release_out(input string nm);
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk({nm, "_rdy_after"}, {30'd0, in_ready, out_valid}, 32'd2);
   endtask

   vec_t vecs[10];
   res_t e, e16, held;

   initial begin
      vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0, 1};
      vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1, 0};
      vecs[2] = '{32'h00000005, 32'h00000007, 0, 1, 32'hFFFFFFFE, 0, 0, 0};
      vecs[3] = '{32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 1, 0};
      vecs[4] = '{32'h00000003, 32'h00000004, 1, 0, 32'h00000008, 0, 0, 0};
      vecs[5] = '{32'h00000007, 32'h00000007, 0, 1, 32'h00000000, 1, 0, 1};
      vecs[6] = '{32'h0000000A, 32'h00000003, 1, 1, 32'h00000007, 1, 0, 0};
      vecs[7] = '{32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1, 1, 1};
      vecs[8] = '{32'h000000FF, 32'h00000001, 0, 0, 32'h00000100, 0, 0, 0};
      vecs[9] = '{32'h12345678, 32'h11111111, 1, 0, 32'h2345678A, 0, 0, 0};

      #12;
      chk("reset_state", {26'd0, in_ready, out_valid, cout, ovf, zero, in_ready16}, 32'h21);
      chk("reset_sum", sum, 0);
      rst_n = 1;

      for (int i = 0; i < 10; i++) begin
         accept(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
         chk("run_in_ready", {31'd0, in_ready}, 0);
         wait_done($sformatf("vec%0d", i));
         e = '{vecs[i].s, vecs[i].c, vecs[i].o, vecs[i].z};
         check_res($sformatf("vec%0d", i), e, model(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 16));
         release_out($sformatf("vec%0d", i));
      end

      // Backpressure: stay in DONE while new operands are offered.
      accept(32'h00000001, 32'h00000002, 0, 0);
      wait_done("bp");
      a = 32'hDEADBEEF; b = 32'h12345678; sub = 1; in_valid = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_sum_stable", sum, 32'h3);
         chk("bp_hold", {30'd0, in_ready, out_valid}, 32'd1);
      end
      release_out("bp");
      in_valid = 0;
      chk("bp_sum_held", sum, 32'h3);
      @(negedge clk);
      chk("bp_no_accept", {30'd0, in_ready, out_valid}, 32'd2);

      // Asynchronous reset between T2 and T3.
      accept(32'h0000FFFF, 32'h00000001, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("rst_mid_run", {27'd0, in_ready, out_valid, cout, ovf, zero}, 32'h10);
      chk("rst_mid_sum", sum, 0);
      @(negedge clk);
      rst_n = 1;
      accept(32'd3, 32'd4, 1, 0);
      wait_done("post_rst");
      check_res("post_rst", '{32'd8, 0, 0, 0}, '{32'd8, 0, 0, 0});
      release_out("post_rst");

      for (int i = 0; i < 1000; i++) begin
         logic [31:0] ra, rb;
         logic rc, rs;
         int stall;
         ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
         stall = $urandom_range(0, 2);
         accept(ra, rb, rc, rs);
         wait_done("rnd");
         e = model(ra, rb, rc, rs, 32);
         e16 = model(ra, rb, rc, rs, 16);
         check_res("rnd", e, e16);
         for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk("rnd_stall_sum", sum, e.s);
         end
         release_out("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
